// File: rtl/div_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined signed divider among NREQ requesters.
// Optional divider/tag alignment checker enabled by defining DIVSCHED_SYNC_CHK_EN.

module div_pipe_scheduler_cnt #(
    parameter int MAX_OUT = 4,
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic req_valid,
    input  logic acc,
    input  logic ret,
    output logic elig
);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

    logic [CW-1:0] cnt;

    // a retire in the same cycle frees a slot, so a full requester may still win
    assign elig = req_valid && ((cnt < MAXC) || ret);

    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (acc && !ret)
            cnt <= cnt + 1'b1;
        else if (ret && !acc)
            cnt <= cnt - 1'b1;
    end
endmodule

module div_pipe_scheduler #(
    parameter int tamanyo = 32,
    parameter int NREQ    = 4,
    parameter int LAT     = 2*tamanyo+1,
    parameter int MAX_OUT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*tamanyo-1:0] req_num,
    input  logic [NREQ*tamanyo-1:0] req_den,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [tamanyo-1:0]      rsp_coc,
    output logic [tamanyo-1:0]      rsp_res,
    output logic                    rsp_err,
    output logic                    div_start,
    output logic [tamanyo-1:0]      div_num,
    output logic [tamanyo-1:0]      div_den,
    input  logic                    div_done,
    input  logic [tamanyo-1:0]      div_coc,
    input  logic [tamanyo-1:0]      div_res,
    output logic                    busy,
    output logic                    err_sync
);
    localparam int W   = tamanyo;
    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           zero;
        logic [W-1:0]   num;
    } tag_t;

    logic [NREQ-1:0][W-1:0] num_v, den_v;
    logic [NREQ-1:0]        elig, gnt, ret;
    logic [IDW-1:0]         ptr, gnt_id;
    logic                   found, acc_zero;
    logic [W-1:0]           acc_num, acc_den;
    logic [LAT:0]           vld_pipe;
    tag_t                   tag_pipe [0:LAT];
    tag_t                   tag_out;

    assign num_v     = req_num;
    assign den_v     = req_den;
    assign req_ready = gnt;
    assign tag_out   = tag_pipe[LAT];

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign ret[i] = vld_pipe[LAT] && (tag_out.id == IDW'(i));
        div_pipe_scheduler_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
            .CLK       (CLK),
            .RST       (RST),
            .req_valid (req_valid[i]),
            .acc       (gnt[i]),
            .ret       (ret[i]),
            .elig      (elig[i])
        );
    end

    // first eligible requester at or above ptr, wrapping
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[(int'(ptr) + k) % NREQ]) begin
                found                           = 1'b1;
                gnt[(int'(ptr) + k) % NREQ]     = 1'b1;
                gnt_id                          = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign acc_num  = num_v[gnt_id];
    assign acc_den  = den_v[gnt_id];
    assign acc_zero = (acc_den == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr       <= '0;
            div_start <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            vld_pipe  <= '0;
            rsp_valid <= '0;
            rsp_coc   <= '0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (found)
                ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            div_start <= found && !acc_zero;
            if (found && !acc_zero) begin
                div_num <= acc_num;
                div_den <= acc_den;
            end
            vld_pipe  <= {vld_pipe[LAT-1:0], found};
            rsp_valid <= '0;
            if (vld_pipe[LAT]) begin
                rsp_valid[tag_out.id] <= 1'b1;
                rsp_err               <= tag_out.zero;
                // divide-by-zero answers come from the tag, the divider is never used
                rsp_coc <= tag_out.zero ? '1 : div_coc;
                rsp_res <= tag_out.zero ? tag_out.num : div_res;
            end
        end
    end

    // tag payload needs no reset: only vld_pipe decides whether an entry exists
    always_ff @(posedge CLK) begin
        tag_pipe[0] <= '{id: gnt_id, zero: acc_zero, num: acc_zero ? acc_num : '0};
        for (int k = 1; k <= LAT; k++)
            tag_pipe[k] <= tag_pipe[k-1];
    end

    assign busy = (|vld_pipe) || div_start || (|rsp_valid);

`ifdef DIVSCHED_SYNC_CHK_EN
    always_ff @(posedge CLK) begin
        if (RST)
            err_sync <= 1'b0;
        else if (div_done != (vld_pipe[LAT] && !tag_out.zero))
            err_sync <= 1'b1;
    end
`else
    logic unused_div_done;
    assign unused_div_done = div_done;
    assign err_sync        = 1'b0;
`endif
endmodule

// File: tb/tb_div_pipe_scheduler.sv
// Directed bench for div_pipe_scheduler with a behavioural fixed-latency divider.
// Define DIVSCHED_SYNC_CHK_EN to also exercise the alignment checker.

module tb_div_pipe_scheduler;
    localparam int W    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 2*W+1;
    localparam int MAXO = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_num = '0;
    logic [NREQ*W-1:0] req_den = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_coc, rsp_res;
    logic              rsp_err;
    logic              div_start;
    logic [W-1:0]      div_num, div_den;
    logic              div_done;
    logic [W-1:0]      div_coc, div_res;
    logic              busy, err_sync;
    logic              inj = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [NREQ-1:0] v;
        logic [W-1:0]    coc;
        logic [W-1:0]    res;
        logic            err;
        int              c;
    } rec_t;
    rec_t rq[$];

    div_pipe_scheduler #(.tamanyo(W), .NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAXO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den),
        .rsp_valid(rsp_valid), .rsp_coc(rsp_coc), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_done(div_done), .div_coc(div_coc), .div_res(div_res),
        .busy(busy), .err_sync(err_sync)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // behavioural divider: LAT cycles from div_start to div_done
    logic [LAT-1:0] dv_p;
    logic [W-1:0]   dq_p [LAT];
    logic [W-1:0]   dr_p [LAT];
    always @(posedge CLK) begin
        if (RST) dv_p <= '0;
        else     dv_p <= {dv_p[LAT-2:0], div_start};
        if (div_start) begin
            dq_p[0] <= $signed(div_num) / $signed(div_den);
            dr_p[0] <= $signed(div_num) % $signed(div_den);
        end
        for (int k = 1; k < LAT; k++) begin
            dq_p[k] <= dq_p[k-1];
            dr_p[k] <= dr_p[k-1];
        end
    end
    assign div_done = dv_p[LAT-1] | inj;
    assign div_coc  = dq_p[LAT-1];
    assign div_res  = dr_p[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        chk("ready_onehot0", 64'($countones(req_ready) <= 1), 64'd1);
        chk("rsp_onehot0", 64'($countones(rsp_valid) <= 1), 64'd1);
        if (rsp_valid != '0)
            rq.push_back('{v: rsp_valid, coc: rsp_coc, res: rsp_res, err: rsp_err, c: cyc});
    end

    // entered and left at posedge+1; returns in the cycle after the accept
    task automatic issue(input int r, input logic [W-1:0] n, input logic [W-1:0] d, output int tacc);
        int b = 0;
        logic ok = 1'b0;
        req_valid[r]       = 1'b1;
        req_num[r*W +: W]  = n;
        req_den[r*W +: W]  = d;
        tacc = -1;
        while (!ok && b < 200) begin
            #1;
            if (req_ready[r]) begin ok = 1'b1; tacc = cyc; end
            @(posedge CLK); #1;
            b++;
        end
        req_valid[r] = 1'b0;
        chk($sformatf("accept_r%0d", r), 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(input int n);
        int b = 0;
        while (rq.size() < n && b < 400) begin
            @(posedge CLK); b++;
        end
        #1;
        chk("rsp_count", 64'(rq.size()), 64'(n));
    endtask

    task automatic chk_rsp(input string tag, input int k, input logic [NREQ-1:0] v,
                           input logic [W-1:0] coc, input logic [W-1:0] res, input logic err,
                           input int c);
        if (k >= rq.size()) begin
            chk({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_v"},   64'(rq[k].v),   64'(v));
            chk({tag, "_coc"}, 64'(rq[k].coc), 64'(coc));
            chk({tag, "_res"}, 64'(rq[k].res), 64'(res));
            chk({tag, "_err"}, 64'(rq[k].err), 64'(err));
            chk({tag, "_cyc"}, 64'(rq[k].c),   64'(c));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, c0;
        logic [NREQ-1:0] expg;
        logic [W-1:0] qv [NREQ];
        logic [W-1:0] rv [NREQ];

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_div_num",   64'(div_num),   64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'({rsp_coc, rsp_res}), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_err_sync",  64'(err_sync),  64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // single op, requester 1
        issue(1, 32'd100, 32'd7, t0);
        chk("t1_div_start", 64'(div_start), 64'd1);
        chk("t1_div_ops",   64'({div_num, div_den}), {32'd100, 32'd7});
        chk("t1_busy",      64'(busy), 64'd1);
        wait_rsp(1);
        chk_rsp("t1", 0, 4'b0010, 32'd14, 32'd2, 1'b0, t0 + 67);
        rq.delete();

        // signed operands
        issue(0, -32'sd100, 32'd7, t0);
        issue(3, 32'd100, -32'sd7, t1);
        wait_rsp(2);
        chk_rsp("t2a", 0, 4'b0001, -32'sd14, -32'sd2, 1'b0, t0 + 67);
        chk_rsp("t2b", 1, 4'b1000, -32'sd14, 32'd2,   1'b0, t1 + 67);
        rq.delete();

        // zero denominator between two ops of requester 2
        issue(2, 32'd20, 32'd3, t0);
        chk("t4_start_a", 64'(div_start), 64'd1);
        issue(2, 32'd55, 32'd0, t1);
        chk("t4_start_z", 64'(div_start), 64'd0);
        chk("t4_hold",    64'({div_num, div_den}), {32'd20, 32'd3});
        issue(2, 32'd9, 32'd4, t2);
        chk("t4_start_b", 64'(div_start), 64'd1);
        wait_rsp(3);
        chk_rsp("t4a", 0, 4'b0100, 32'd6, 32'd2, 1'b0, t0 + 67);
        chk_rsp("t4z", 1, 4'b0100, 32'hFFFF_FFFF, 32'd55, 1'b1, t1 + 67);
        chk_rsp("t4b", 2, 4'b0100, 32'd2, 32'd1, 1'b0, t2 + 67);
        repeat (3) @(posedge CLK);
        #1;
        chk("t4_rsp_hold", 64'({rsp_coc, rsp_res}), {32'd2, 32'd1});
        chk("t4_idle",     64'({rsp_valid, busy}), 64'd0);
        rq.delete();

        // reset with operations in flight
        issue(0, 32'd10, 32'd2, t0);
        issue(1, 32'd11, 32'd2, t0);
        issue(2, 32'd12, 32'd2, t0);
        repeat (30) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("t5_busy",      64'(busy),      64'd0);
        chk("t5_start",     64'(div_start), 64'd0);
        chk("t5_err_sync",  64'(err_sync),  64'd0);
        repeat (100) @(posedge CLK);
        #1;
        chk("t5_no_rsp", 64'(rq.size()), 64'd0);
        issue(3, 32'd77, -32'sd5, t0);
        wait_rsp(1);
        chk_rsp("t5n", 0, 4'b1000, -32'sd15, 32'd2, 1'b0, t0 + 67);
        rq.delete();
        repeat (3) @(posedge CLK);
        #1;

        // all requesters continuously valid; ptr is 0 here
        qv = '{32'd33, 32'd50, 32'd60, 32'd57};
        rv = '{32'd1,  32'd0,  32'd0,  32'd1};
        req_num = {32'd400, 32'd300, 32'd200, 32'd100};
        req_den = {32'd7,   32'd5,   32'd4,   32'd3};
        req_valid = 4'hF;
        c0 = cyc;
        for (int c = 0; c < 68; c++) begin
            #1;
            if (c < 16)       expg = NREQ'(1 << (c % 4));
            else if (c == 66) expg = 4'b0001;
            else if (c == 67) expg = 4'b0010;
            else              expg = '0;
            chk($sformatf("t3_gnt_c%0d", c), 64'(req_ready), 64'(expg));
            @(posedge CLK); #1;
        end
        req_valid = '0;
        wait_rsp(18);
        for (int k = 0; k < 16; k++)
            chk_rsp($sformatf("t3r%0d", k), k, NREQ'(1 << (k % 4)), qv[k % 4], rv[k % 4], 1'b0, c0 + k + 67);
        chk_rsp("t3r16", 16, 4'b0001, qv[0], rv[0], 1'b0, c0 + 66 + 67);
        chk_rsp("t3r17", 17, 4'b0010, qv[1], rv[1], 1'b0, c0 + 67 + 67);
        rq.delete();
        repeat (3) @(posedge CLK);
        #1;
        chk("t6_pre_err_sync", 64'(err_sync), 64'd0);
        chk("t6_pre_busy",     64'(busy),     64'd0);

        // spurious div_done with nothing in flight
        inj = 1'b1;
        @(posedge CLK); #1;
        inj = 1'b0;
`ifdef DIVSCHED_SYNC_CHK_EN
        chk("t6_err_set", 64'(err_sync), 64'd1);
        repeat (10) @(posedge CLK);
        #1;
        chk("t6_err_sticky", 64'(err_sync), 64'd1);
`else
        chk("t6_err_tied", 64'(err_sync), 64'd0);
`endif
        chk("t6_no_rsp", 64'(rq.size()), 64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("t6_err_clr", 64'(err_sync), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_pipe_scheduler.md
Name: div_pipe_scheduler

Overview:
Shares one pipelined signed divider (fixed latency, one new operation per cycle) among N requesters. Round-robin arbitration issues at most one division per cycle. A tag pipeline tracks requester ID and flags in step with the divider, so each result returns to its originator. Requests with a zero denominator never reach the divider; they return an error response through the same tag pipeline so per-requester ordering holds.

Parameters:
tamanyo, 32, operand/result width W
NREQ, 4, number of requesters (2..8)
LAT, 2*tamanyo+1, divider latency: div_start cycle to div_done cycle
MAX_OUT, 4, max in-flight operations per requester (1..15)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_num  in  NREQ*W  numerators; requester i uses slice [i*W +: W]
req_den  in  NREQ*W  denominators; same slicing
rsp_valid  out  NREQ  one-cycle response strobe (one-hot or zero)
rsp_coc  out  W  quotient, shared by all requesters
rsp_res  out  W  remainder, shared
rsp_err  out  1  response is a divide-by-zero error
div_start  out  1  issue strobe to divider
div_num  out  W  divider numerator
div_den  out  W  divider denominator
div_done  in  1  divider result valid
div_coc  in  W  divider quotient
div_res  in  W  divider remainder
busy  out  1  any operation in flight
err_sync  out  1  sticky divider/tag misalignment (see Optional Feature)

Behaviour:
- Reset (RST high at an edge): ptr=0, all outstanding counters 0, tag pipeline cleared, div_start=0, div_num=div_den=0, rsp_valid=0, rsp_coc=rsp_res=0, rsp_err=0, busy=0, err_sync=0. In-flight operations are discarded without a response. The divider shares RST, so its pipeline is flushed too.
- Eligibility: requester i is eligible when req_valid[i]=1 and out_cnt[i]<MAX_OUT, or when a response for i retires in the same cycle (out_cnt[i]==MAX_OUT with a retire counts as eligible).
- Arbitration:
  - Combinational round-robin over eligible requesters, searching from ptr upward with wrap.
  - req_ready[g]=1 for the winner g only.
  - On accept, ptr <= (g+1) mod NREQ. With no winner, ptr holds.
- Issue (registered):
  - Accept in cycle T, den!=0: cycle T+1 has div_start=1, div_num/div_den equal to the accepted operands.
  - Accept with den==0: div_start=0 in T+1, div_num/div_den hold.
  - No accept: div_start=0.
- Tag pipeline:
  - LAT+1 entries {v, id, zero, num}.
  - Entry written on accept; entry exits at cycle T+1+LAT, aligned with div_done.
  - num is stored only for zero-den entries.
- Response, registered, at cycle T+2+LAT, for the tag exiting with v=1:
  - rsp_valid[id]=1.
  - zero=0: rsp_coc=div_coc, rsp_res=div_res, rsp_err=0.
  - zero=1: rsp_coc=all ones, rsp_res=stored num, rsp_err=1.
  - With no exiting tag, rsp_valid=0 and the data outputs hold.
  - Responses cannot be back-pressured.
- Counters:
  - out_cnt[i] increments on accept and decrements on response retire (the tag exit cycle).
  - Simultaneous accept and retire for the same i leaves the count unchanged.
  - A counter never exceeds MAX_OUT and never wraps.
- Throughput: one accept per cycle sustained. Responses leave in issue order.
- busy = any tag entry valid, or div_start, or rsp_valid.

Optional Feature:
Macro DIVSCHED_SYNC_CHK_EN.
- Defined: at each tag exit, a mismatch sets err_sync=1. A mismatch is div_done != (v & ~zero), or div_done high with no valid tag. err_sync stays 1 until RST. The response is still produced from the tag.
- Undefined: err_sync is tied 0 and the check logic is absent.

Test Plan:
- Single op, requester 1, num=100, den=7, accept at T -> div_start at T+1; rsp_valid=4'b0010 at T+67 with coc=14, res=2, err=0 (W=32, LAT=65).
- Signed ops: num=-100, den=7 -> coc=-14, res=-2. num=100, den=-7 -> coc=-14, res=2.
- All 4 requesters valid continuously for 40 cycles -> grants cycle 0,1,2,3,0,... Each requester is stalled after 4 accepts until its first response retires. No cycle has two ready bits set.
- Zero denominator, requester 2, num=55, den=0, between two valid ops from requester 2 -> div_start not asserted for it. Responses arrive in order; the middle one has err=1, coc=32'hFFFFFFFF, res=55.
- RST asserted 30 cycles after 3 issues -> no rsp_valid afterwards; counters, busy and err_sync are 0. A new op after reset completes correctly.
- With DIVSCHED_SYNC_CHK_EN defined, a bench-injected spurious div_done with no tag -> err_sync=1 next cycle and stays 1 until RST.
